// File: rtl/peak_hold_vu_meter_if.sv
// Bundles the audio sample stream and the LED/level/clip display outputs of
// the peak-hold VU meter. The master drives samples and controls; the slave
// (the meter) drives the display outputs.
interface peak_hold_vu_meter_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int NUM_LEDS = 10,
  parameter int LVL_W    = $clog2(NUM_LEDS + 1)
);
  logic [NUM_CH*DATA_W-1:0]   audio_in;
  logic                       audio_valid;
  logic                       dot_mode;
  logic                       clear_hold;
  logic [NUM_CH*NUM_LEDS-1:0] led_out;
  logic [NUM_CH*LVL_W-1:0]    level_out;
  logic [NUM_CH-1:0]          clip;

  modport master (
    output audio_in, audio_valid, dot_mode, clear_hold,
    input  led_out, level_out, clip
  );

  modport slave (
    input  audio_in, audio_valid, dot_mode, clear_hold,
    output led_out, level_out, clip
  );
endinterface

// File: rtl/peak_hold_vu_meter.sv
// Multi-channel peak-hold VU meter. Each channel tracks the absolute peak of
// its sample stream, decays it exponentially on a shared prescaled tick, maps
// it onto log-spaced LED thresholds and shows a held peak marker plus a
// stretched clip flag. All per-channel state updates on the edge that accepts
// a sample; the display registers follow one edge later.
module peak_hold_vu_meter #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 2,
  parameter int NUM_LEDS    = 10,
  parameter int STEP_BITS   = 2,
  parameter int DECAY_DIV   = 50000,
  parameter int DECAY_SHIFT = 7,
  parameter int HOLD_TICKS  = 500,
  parameter int CLIP_TICKS  = 250,
  parameter int LVL_W       = $clog2(NUM_LEDS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  peak_hold_vu_meter_if.slave  bus
);

  localparam int PRE_W  = $clog2(DECAY_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int CLIP_W = $clog2(CLIP_TICKS + 1);
  // Samples at or beyond positive full scale count as clipping.
  localparam logic [DATA_W-1:0] CLIP_LIM = {1'b0, {(DATA_W-1){1'b1}}};

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_W'(DECAY_DIV - 1));

  // Free-running decay prescaler shared by every channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic signed [DATA_W-1:0] sample;
    logic [DATA_W-1:0]        mag;
    logic [DATA_W-1:0]        peak;
    logic [DATA_W-1:0]        peak_next;
    logic [DATA_W-1:0]        decay_amt;
    logic                     attack;
    logic                     clip_event;
    logic [LVL_W-1:0]         level_next;
    logic [LVL_W-1:0]         level;
    logic [LVL_W-1:0]         hold_idx;
    logic [HOLD_W-1:0]        hold_cnt;
    logic [CLIP_W-1:0]        clip_cnt;
    logic [NUM_LEDS-1:0]      led_next;
    logic [NUM_LEDS-1:0]      led_q;
    logic [LVL_W-1:0]         level_q;
    logic                     clip_q;

    assign sample = bus.audio_in[gi*DATA_W +: DATA_W];
    // Two's complement negation in DATA_W bits: the most-negative input maps
    // to 2^(DATA_W-1), which is representable as unsigned.
    assign mag        = sample[DATA_W-1] ? (~sample + DATA_W'(1)) : sample;
    assign attack     = bus.audio_valid && (mag > peak);
    assign clip_event = bus.audio_valid && (mag >= CLIP_LIM);

    // Next peak: attack takes priority, otherwise decay on tick with a floor
    // step of 1 so the peak always returns to zero.
    always_comb begin
      decay_amt = peak >> DECAY_SHIFT;
      if (decay_amt == '0 && peak != '0) decay_amt = DATA_W'(1);
      peak_next = peak;
      if (attack)    peak_next = mag;
      else if (tick) peak_next = peak - decay_amt;
    end

    // Level of the next peak: thresholds are monotonic, so the highest one
    // reached equals the count of thresholds reached.
    always_comb begin
      level_next = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (peak_next >= (DATA_W'(1) << (DATA_W - 2 - (NUM_LEDS - 1 - i) * STEP_BITS)))
          level_next = LVL_W'(i + 1);
      end
    end

    // Peak, level, hold marker and clip stretch state.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        peak     <= '0;
        level    <= '0;
        hold_idx <= '0;
        hold_cnt <= '0;
        clip_cnt <= '0;
      end else begin
        peak  <= peak_next;
        level <= level_next;
        if (bus.clear_hold) begin
          hold_idx <= '0;
          hold_cnt <= '0;
        end else if (level_next > hold_idx) begin
          hold_idx <= level_next;
          hold_cnt <= HOLD_W'(HOLD_TICKS);
        end else if (tick) begin
          if (hold_cnt != '0)            hold_cnt <= hold_cnt - HOLD_W'(1);
          else if (hold_idx > level_next) hold_idx <= hold_idx - LVL_W'(1);
        end
        if (clip_event)                     clip_cnt <= CLIP_W'(CLIP_TICKS);
        else if (bus.clear_hold)            clip_cnt <= '0;
        else if (tick && clip_cnt != '0)    clip_cnt <= clip_cnt - CLIP_W'(1);
      end
    end

    // LED pattern: bar or dot for the level, plus the held marker.
    always_comb begin
      led_next = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_next[i] = (bus.dot_mode ? (level == LVL_W'(i + 1)) : (level > LVL_W'(i)))
                      || (hold_idx == LVL_W'(i + 1));
      end
    end

    // Registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        led_q   <= '0;
        level_q <= '0;
        clip_q  <= 1'b0;
      end else begin
        led_q   <= led_next;
        level_q <= level;
        clip_q  <= (clip_cnt != '0);
      end
    end

    assign bus.led_out[gi*NUM_LEDS +: NUM_LEDS] = led_q;
    assign bus.level_out[gi*LVL_W +: LVL_W]     = level_q;
    assign bus.clip[gi]                         = clip_q;
  end

endmodule

// File: doc/peak_hold_vu_meter.md
# peak_hold_vu_meter

Multi-channel level meter with peak-hold and clip indication; the parametrised successor of the single-bar stereo VU meter. It sits on the audio sample stream after the codec interface and drives the board LED bars. Per channel it tracks absolute peak with prescaled exponential decay and maps the peak to a log-spaced LED bar or dot, with a held peak marker and a stretched clip flag.

## Interface
- DATA_W, 32: signed sample width.
- NUM_CH, 2: channel count.
- NUM_LEDS, 10: LEDs per channel.
- STEP_BITS, 2: threshold spacing in powers of two (2 = 12 dB per LED).
- DECAY_DIV, 50000: clocks per decay tick.
- DECAY_SHIFT, 7: decay = peak >> DECAY_SHIFT per tick.
- HOLD_TICKS, 500: ticks the peak marker holds before falling.
- CLIP_TICKS, 250: ticks the clip flag stays set after the last clip.
- LVL_W, $clog2(NUM_LEDS+1): level index width (derived).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- audio_in  in  NUM_CH*DATA_W  signed samples, channel c at [c*DATA_W +: DATA_W].
- audio_valid  in  1  all channels valid this cycle.
- dot_mode  in  1  0 = bar, 1 = dot.
- clear_hold  in  1  single-cycle pulse, clears hold markers and clip flags.
- led_out  out  NUM_CH*NUM_LEDS  channel c at [c*NUM_LEDS +: NUM_LEDS], bit 0 = lowest LED.
- level_out  out  NUM_CH*LVL_W  current level index per channel.
- clip  out  NUM_CH  per-channel clip flag.

## Operation
- Legal configuration: DATA_W-2 >= (NUM_LEDS-1)*STEP_BITS, DECAY_DIV >= 2.
- Magnitude: mag = |sample| as DATA_W-bit unsigned. The most-negative input gives 2^(DATA_W-1) with no overflow.
- Prescaler: a free-running counter 0..DECAY_DIV-1. It asserts `tick` for one cycle when count == DECAY_DIV-1, then wraps to 0.
- Peak, per channel:
  - Attack: if audio_valid and mag > peak, then peak <= mag. Attack wins over a coincident tick, and that channel's decay is skipped.
  - Decay: on tick with no attack, d = peak >> DECAY_SHIFT. If d == 0 and peak != 0, then d = 1, so the peak always reaches 0. Then peak <= peak - d. A peak of 0 stays 0.
- Thresholds: T(i) = 2^(DATA_W-2-(NUM_LEDS-i)*STEP_BITS) for i = 1..NUM_LEDS.
  - level = number of i with peak >= T(i), range 0..NUM_LEDS.
  - Defaults: T(10) = 2^30, T(1) = 2^12.
- Hold marker, per channel (hold_idx, hold_cnt), evaluated in priority order:
  1. clear_hold: hold_idx <= 0, hold_cnt <= 0.
  2. level > hold_idx: hold_idx <= level, hold_cnt <= HOLD_TICKS.
  3. On tick: if hold_cnt > 0, decrement hold_cnt. Otherwise, if hold_idx > level, hold_idx decrements by 1 per tick.
  - hold_idx never goes below the current level.
- Display, per channel:
  - Bar mode: LEDs [level-1:0] lit.
  - Dot mode: only LED level-1 lit.
  - Both modes: LED hold_idx-1 is also lit when hold_idx > 0.
  - Level 0 with hold_idx 0: all LEDs off.
- Clip, per channel:
  - Set when audio_valid and mag >= 2^(DATA_W-1)-1, and clip_cnt <= CLIP_TICKS on that event.
  - Otherwise clip_cnt decrements on tick; clip clears when clip_cnt reaches 0.
  - clear_hold clears clip unless a clip event occurs in the same cycle; the clip event wins.
- Channels are fully independent. All channels share the prescaler and dot_mode.

## Timing
- Reset (asynchronous, any time, including mid-hold or mid-decay) clears everything to 0: prescaler, peak, hold_idx, hold_cnt, clip_cnt, led_out, level_out, clip.
- The first tick after reset release occurs on clock DECAY_DIV.
- Latency: sample accepted at edge N updates peak at edge N. level_out, led_out and clip are registered and reflect it at edge N+1.
- Mode change: dot_mode is sampled combinationally into the output register, so a change is visible at the next edge.
- clear_hold effect is visible at the outputs one edge after the pulse.
- Samples with audio_valid low are ignored. There is no backpressure, and one sample per cycle is accepted.

## Test plan
- Reset then silence: led_out = 0, level_out = 0 and clip = 0 for all channels across 3*DECAY_DIV cycles.
- Ch0 single sample 0x4000_0000 with valid:
  - Two edges later, ch0 level_out = 10, led_out = 0x3FF, and ch1 is unaffected.
  - Dot mode then shows 0x200.
- Ch0 sample 0x0000_1000 (= T(1)) gives level 1; 0x0000_0FFF gives level 0. Sample 0x8000_0000 (most negative) gives level 10 and clip = 1.
- Peak 0x4000_0000 then silence:
  - Peak decays each tick until level falls below 10.
  - The hold marker stays at LED 9 for HOLD_TICKS ticks, then falls one LED per tick, never below level.
  - clear_hold mid-hold drops the marker on the next edge.
- Clip stretch and decay floor:
  - After a full-scale sample, clip stays 1 for CLIP_TICKS ticks, then drops.
  - A second clip re-arms the count.
  - A peak of 5 with DECAY_SHIFT 7 reaches 0 after exactly 5 ticks.
- Collision and reset:
  - A valid larger sample on the tick cycle: peak equals the sample, with no decay.
  - Assert reset mid-decay: all outputs are 0 immediately, asynchronously.
